fetch_queue: RTL and testbench

- Receiver end of the fetch-to-decode interface.
- Accepts {pc, instr, valid} triples produced by the fetch stage and buffers them in a small show-ahead FIFO.
- Presents the oldest entry to the decode stage with a valid/stall handshake.
- Backpressures fetch via stallF when full, and drops all buffered instructions on a memory-stage redirect (PCSrcM).

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 66 ++++++
 tb/tb_fetch_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle seen by the fetch queue.
// master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH_POWER = 2,
  parameter int W = 32
);
  logic [W-1:0] pcF;
  logic [W-1:0] instrF;
  logic validF;
  logic flush;
  logic stallD;
  logic stallF;
  logic [W-1:0] pcD;
  logic [W-1:0] instrD;
  logic validD;
  logic [DEPTH_POWER:0] count;

  modport master (
    output pcF, instrF, validF,
    output flush, stallD,
    input stallF, pcD, instrD,
    input validD, count
  );

  modport slave (
    input pcF, instrF, validF,
    input flush, stallD,
    output stallF, pcD, instrD,
    output validD, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Show-ahead FIFO between fetch and decode.
// Squeezes out bubbles and drops everything on a redirect.
module fetch_queue #(
  parameter int DEPTH_POWER = 2,
  parameter int W = 32
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.slave q
);
  localparam int DEPTH = 1 << DEPTH_POWER;
  localparam logic [DEPTH_POWER:0] FULL_CNT =
    (DEPTH_POWER+1)'(DEPTH);

  typedef logic [DEPTH_POWER-1:0] ptr_t;

  logic [2*W-1:0] mem [DEPTH];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic [DEPTH_POWER:0] cnt;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [2*W-1:0] head;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign push  = q.validF && !full && !q.flush;
  assign pop   = !empty && !q.stallD && !q.flush;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {q.pcF, q.instrF};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign q.stallF = full;
  assign q.count  = cnt;
  assign q.validD = !empty && !q.flush;
  assign q.pcD    = q.validD ? head[2*W-1:W] : '0;
  assign q.instrD = q.validD ? head[W-1:0] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue.
// Stimulus pushes expectations; a negedge monitor checks them.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nerr = 0;
  int nchk = 0;
  int mcnt = 0;
  logic [63:0] sb [$];

  fetch_queue_if #(.DEPTH_POWER(2), .W(32)) q ();

  fetch_queue #(.DEPTH_POWER(2), .W(32)) dut (
    .clk(clk),
    .reset(reset),
    .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Monitor: inputs are stable mid-cycle.
  always @(negedge clk) begin
    logic ev;
    ev = (mcnt != 0) && !q.flush;
    chk("count", 64'(q.count), 64'(mcnt));
    chk("stallF", 64'(q.stallF), 64'(mcnt == 4));
    chk("validD", 64'(q.validD), 64'(ev));
    if (!q.validD) begin
      chk("zero_out", {q.pcD, q.instrD}, 64'h0);
    end else if (sb.size() == 0) begin
      chk("sb_empty", {q.pcD, q.instrD}, 64'hX);
    end else begin
      chk("head", {q.pcD, q.instrD}, sb[0]);
      if (!q.stallD)
        void'(sb.pop_front());
    end
  end

  // One clock of stimulus; model updated at the edge.
  task automatic step(input logic v,
                      input logic [31:0] pc,
                      input logic [31:0] ins,
                      input logic fl,
                      input logic sd);
    logic p;
    logic o;
    q.validF = v;
    q.pcF    = pc;
    q.instrF = ins;
    q.flush  = fl;
    q.stallD = sd;
    @(posedge clk);
    if (fl) begin
      mcnt = 0;
      sb.delete();
    end else begin
      p = v && (mcnt != 4);
      o = (mcnt != 0) && !sd;
      if (p)
        sb.push_back({pc, ins});
      mcnt = mcnt + int'(p) - int'(o);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mcnt != 0; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drained", 64'(mcnt), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic acc;
    q.validF = 1'b0;
    q.pcF    = '0;
    q.instrF = '0;
    q.flush  = 1'b0;
    q.stallD = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_validD", 64'(q.validD), 64'd0);
    chk("rst_pcD", 64'(q.pcD), 64'd0);
    chk("rst_instrD", 64'(q.instrD), 64'd0);
    chk("rst_stallF", 64'(q.stallF), 64'd0);
    chk("rst_count", 64'(q.count), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: three instructions straight through
    step(1, 32'h4, 32'h00500093, 0, 0);
    step(1, 32'h8, 32'h00a00113, 0, 0);
    step(1, 32'hC, 32'h002081b3, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    chk("t1_count", 64'(q.count), 64'd0);

    // 2: fill while stalled, fifth refused
    for (int i = 0; i < 5; i++)
      step(1, 32'h20 + 32'(i*4),
           32'hB0 + 32'(i), 0, 1);
    chk("t2_stallF", 64'(q.stallF), 64'd1);
    chk("t2_head", 64'(q.pcD), 64'h20);

    // 3: pop from full, push refused
    step(1, 32'h99, 32'h99, 0, 0);
    chk("t3_count", 64'(q.count), 64'd3);
    chk("t3_stallF", 64'(q.stallF), 64'd0);
    drain();

    // 4: flush with three queued
    for (int i = 0; i < 3; i++)
      step(1, 32'h40 + 32'(i*4),
           32'hC0 + 32'(i), 0, 1);
    q.flush = 1'b1;
    #1;
    chk("t4_validD", 64'(q.validD), 64'd0);
    step(1, 32'h100, 32'h111, 1, 1);
    chk("t4_count", 64'(q.count), 64'd0);
    step(1, 32'h200, 32'h222, 0, 0);
    chk("t4_pcD", 64'(q.pcD), 64'h200);
    drain();

    // 5: ten across the wrap, decode toggling
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      acc = (mcnt != 4);
      step(1, 32'h1000 + 32'(n*4),
           32'hA000 + 32'(n), 0, c[0]);
      if (acc)
        n++;
    end
    chk("t5_sent", 64'(n), 64'd10);
    drain();
    chk("t5_sb", 64'(sb.size()), 64'd0);

    // 6: async reset mid-cycle with two queued
    step(1, 32'h300, 32'h3, 0, 1);
    step(1, 32'h304, 32'h4, 0, 1);
    q.validF = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_validD", 64'(q.validD), 64'd0);
    chk("t6_count", 64'(q.count), 64'd0);
    mcnt = 0;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, 32'h400, 32'h5, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end
endmodule
